// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush controller for load-use, taken-branch and data-memory-wait hazards.
module hazard_stall_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read_id_ex,
  input  logic             RegWrite_id_ex,
  input  logic [3:0]       write_address_id_ex,
  input  logic [3:0]       read_address1_if_id,
  input  logic [3:0]       read_address2_if_id,
  input  logic             uses_rs1_if_id,
  input  logic             uses_rs2_if_id,
  input  logic             branch_taken_ex,
  input  logic             mem_req_ex_mem,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             ex_mem_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);
  typedef enum logic [1:0] {RUN, LSTALL, FLUSH, MEM_WAIT} state_t;
  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             lu, mw, do_freeze, do_flush, do_stall;
  assign lu = mem_read_id_ex & RegWrite_id_ex & (write_address_id_ex != 4'hF) &
              ((uses_rs1_if_id & (read_address1_if_id == write_address_id_ex)) |
               (uses_rs2_if_id & (read_address2_if_id == write_address_id_ex)));
  assign mw = mem_req_ex_mem & ~mem_ready;
  // The memory wait outranks everything; a branch squashes any same-cycle load-use.
  assign do_freeze = (state_q == MEM_WAIT) | mw;
  assign do_flush  = ~do_freeze & ((state_q == FLUSH) | ((state_q == RUN) & branch_taken_ex));
  assign do_stall  = ~do_freeze & ~do_flush & ((state_q == LSTALL) | ((state_q == RUN) & lu));
  assign pc_write     = rst_n & ~do_freeze & ~do_stall;
  assign if_id_write  = rst_n & ~do_freeze & ~do_stall;
  assign id_ex_write  = rst_n & ~do_freeze;
  assign id_ex_bubble = ~rst_n | do_flush | do_stall;
  assign if_id_flush  = rst_n & do_flush;
  assign ex_mem_hold  = rst_n & do_freeze;
  assign mem_timeout  = mem_timeout_q;
  assign stall_count  = stall_count_q;
  // cnt holds the cycles still owed including the current one, so cnt<=1 means last cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q == MEM_WAIT) begin
      if (!mw) begin
        state_d = RUN;
      end else if (cnt_q <= 8'd1) begin
        state_d       = RUN;
        mem_timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end else if (mw) begin
      state_d = MEM_WAIT;
      cnt_d   = 8'(MEM_TIMEOUT - 1);
    end else if (state_q == FLUSH || state_q == LSTALL) begin
      state_d = (cnt_q <= 8'd1) ? RUN : state_q;
      cnt_d   = (cnt_q <= 8'd1) ? 8'd0 : cnt_q - 8'd1;
    end else if (branch_taken_ex) begin
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      cnt_d   = 8'(FLUSH_CYCLES - 1);
    end else if (lu) begin
      state_d = (LOAD_STALL_CYCLES > 1) ? LSTALL : RUN;
      cnt_d   = 8'(LOAD_STALL_CYCLES - 1);
    end
    stall_count_d = (!pc_write && !(&stall_count_q)) ? stall_count_q + 1'b1 : stall_count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: two configurations driven in parallel, checked each cycle against a counter-based model.
module tb_hazard_stall_unit;
  logic clk = 1'b0, rst_n;
  logic mem_read, regw, u1s, u2s, br, req, rdy;
  logic [3:0] wa, ra1, ra2;
  logic pc0, ifw0, idw0, bub0, fl0, hold0, to0;
  logic pc1, ifw1, idw1, bub1, fl1, hold1, to1;
  logic [15:0] sc0, sc1;
  logic [5:0] outs0, outs1;
  int tests = 0, fails = 0;
  bit chk_en = 1'b0;
  int p_ls[2] = '{1, 3};
  int p_fl[2] = '{1, 2};
  int p_mt[2] = '{255, 4};
  int ls_left[2], fl_left[2], wait_n[2], sc[2];
  bit waiting[2], to[2];
  always #5 clk = ~clk;
  assign outs0 = {pc0, ifw0, idw0, bub0, fl0, hold0};
  assign outs1 = {pc1, ifw1, idw1, bub1, fl1, hold1};
  hazard_stall_unit u0 (
    .clk(clk), .rst_n(rst_n), .mem_read_id_ex(mem_read), .RegWrite_id_ex(regw),
    .write_address_id_ex(wa), .read_address1_if_id(ra1), .read_address2_if_id(ra2),
    .uses_rs1_if_id(u1s), .uses_rs2_if_id(u2s), .branch_taken_ex(br),
    .mem_req_ex_mem(req), .mem_ready(rdy), .pc_write(pc0), .if_id_write(ifw0),
    .id_ex_write(idw0), .id_ex_bubble(bub0), .if_id_flush(fl0), .ex_mem_hold(hold0),
    .mem_timeout(to0), .stall_count(sc0));
  hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .mem_read_id_ex(mem_read), .RegWrite_id_ex(regw),
    .write_address_id_ex(wa), .read_address1_if_id(ra1), .read_address2_if_id(ra2),
    .uses_rs1_if_id(u1s), .uses_rs2_if_id(u2s), .branch_taken_ex(br),
    .mem_req_ex_mem(req), .mem_ready(rdy), .pc_write(pc1), .if_id_write(ifw1),
    .id_ex_write(idw1), .id_ex_bubble(bub1), .if_id_flush(fl1), .ex_mem_hold(hold1),
    .mem_timeout(to1), .stall_count(sc1));
  task automatic cmp(input string n, input int m, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s u%0d @%0t: got %0h expected %0h", n, m, $time, got, exp);
    end
  endtask
  function automatic bit f_mw();
    return req && !rdy;
  endfunction
  function automatic bit f_lu();
    return mem_read && regw && wa != 4'hF && ((u1s && ra1 == wa) || (u2s && ra2 == wa));
  endfunction
  // {pc_write, if_id_write, id_ex_write, id_ex_bubble, if_id_flush, ex_mem_hold}
  function automatic logic [5:0] exp_out(input int m);
    if (!rst_n) return 6'b000100;
    if (waiting[m] || f_mw()) return 6'b000001;
    if (fl_left[m] > 0) return 6'b111110;
    if (ls_left[m] > 0) return 6'b001100;
    if (br) return 6'b111110;
    if (f_lu()) return 6'b001100;
    return 6'b111000;
  endfunction
  always @(negedge clk) if (chk_en) begin
    cmp("outs", 0, 32'(outs0), 32'(exp_out(0)));
    cmp("outs", 1, 32'(outs1), 32'(exp_out(1)));
    cmp("timeout", 0, 32'(to0), 32'(to[0]));
    cmp("timeout", 1, 32'(to1), 32'(to[1]));
    cmp("stall_count", 0, 32'(sc0), 32'(sc[0]));
    cmp("stall_count", 1, 32'(sc1), 32'(sc[1]));
  end
  always @(posedge clk) if (chk_en) begin
    for (int m = 0; m < 2; m++) begin
      logic [5:0] e;
      e = exp_out(m);
      if (!rst_n) begin
        ls_left[m] = 0; fl_left[m] = 0; wait_n[m] = 0; sc[m] = 0; waiting[m] = 0; to[m] = 0;
      end else begin
        if (!e[5] && sc[m] < 65535) sc[m]++;
        if (waiting[m]) begin
          if (!f_mw()) waiting[m] = 0;
          else if (wait_n[m] + 1 >= p_mt[m]) begin to[m] = 1; waiting[m] = 0; end
          else wait_n[m]++;
        end else if (f_mw()) begin
          waiting[m] = 1; wait_n[m] = 1; ls_left[m] = 0; fl_left[m] = 0;
        end else if (fl_left[m] > 0) fl_left[m]--;
        else if (ls_left[m] > 0) ls_left[m]--;
        else if (br) fl_left[m] = p_fl[m] - 1;
        else if (f_lu()) ls_left[m] = p_ls[m] - 1;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    mem_read = 0; regw = 0; wa = 0; ra1 = 0; ra2 = 0; u1s = 0; u2s = 0; br = 0; req = 0; rdy = 0;
  endtask
  task automatic set_lu(input logic [3:0] w, input logic [3:0] a1, input logic [3:0] a2,
                        input logic s1, input logic s2);
    idle();
    mem_read = 1; regw = 1; wa = w; ra1 = a1; ra2 = a2; u1s = s1; u2s = s2;
  endtask
  // {mem_read, regw, wa, ra1, ra2, uses1, uses2, br, req, rdy}
  logic [19:0] vecs[12] = '{
    {1'b1,1'b1,4'd2,4'd2,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0},
    {1'b0,1'b1,4'd2,4'd2,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0},
    {1'b1,1'b0,4'd2,4'd2,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0},
    {1'b1,1'b1,4'd6,4'd1,4'd6,1'b0,1'b1,1'b0,1'b0,1'b0},
    {1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,1'b1,1'b0,1'b0},
    {1'b1,1'b1,4'd9,4'd9,4'd9,1'b1,1'b1,1'b0,1'b1,1'b0},
    {1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b1},
    {1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,1'b1,1'b1,1'b1},
    {1'b1,1'b1,4'd1,4'd1,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0},
    {1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,1'b1,1'b0,1'b0},
    {1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0},
    {1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0}};
  initial begin
    rst_n = 0;
    idle();
    @(posedge clk);
    #1 chk_en = 1;
    tick();
    cmp("rst_outs", 0, 32'(outs0), 32'h04);
    cmp("rst_sc", 1, 32'(sc1), 0);
    rst_n = 1;
    #1 cmp("run_outs", 0, 32'(outs0), 32'h38);
    tick();
    set_lu(4'd3, 4'd3, 4'd0, 1, 0);
    #1 cmp("t1_stall", 0, 32'(outs0), 32'h0C);
    tick();
    idle();
    #1 cmp("t1_after", 0, 32'(outs0), 32'h38);
    cmp("t1_sc", 0, 32'(sc0), 1);
    cmp("t1_u1_stall", 1, 32'(outs1), 32'h0C);
    tick();
    tick();
    cmp("t1_u1_sc", 1, 32'(sc1), 3);
    cmp("t1_u1_run", 1, 32'(outs1), 32'h38);
    set_lu(4'hF, 4'hF, 4'd0, 1, 0);
    #1 cmp("t2_r15", 0, 32'(outs0), 32'h38);
    tick();
    set_lu(4'd3, 4'd3, 4'd3, 0, 0);
    #1 cmp("t2_nouse", 0, 32'(outs0), 32'h38);
    tick();
    idle();
    #1 cmp("t2_sc", 0, 32'(sc0), 1);
    set_lu(4'd5, 4'd0, 4'd5, 0, 1);
    tick();
    idle();
    tick();
    tick();
    set_lu(4'd4, 4'd4, 4'd0, 1, 0);
    br = 1;
    #1 cmp("t3_flush", 0, 32'(outs0), 32'h3E);
    tick();
    idle();
    #1 cmp("t3_after", 0, 32'(outs0), 32'h38);
    cmp("t3_u1_flush2", 1, 32'(outs1), 32'h3E);
    tick();
    cmp("t3_sc", 0, 32'(sc0), 2);
    req = 1;
    #1 cmp("t4_freeze", 0, 32'(outs0), 32'h01);
    tick();
    tick();
    rdy = 1;
    #1 cmp("t4_ready_freeze", 0, 32'(outs0), 32'h01);
    tick();
    idle();
    #1 cmp("t4_run", 0, 32'(outs0), 32'h38);
    cmp("t4_sc", 0, 32'(sc0), 5);
    set_lu(4'd7, 4'd7, 4'd0, 1, 0);
    tick();
    idle();
    req = 1;
    tick();
    rdy = 1;
    tick();
    idle();
    repeat (3) tick();
    req = 1;
    repeat (4) tick();
    idle();
    #1 cmp("t5_timeout", 1, 32'(to1), 1);
    cmp("t5_no_timeout", 0, 32'(to0), 0);
    cmp("t5_forced_run", 1, 32'(outs1), 32'h38);
    repeat (3) tick();
    cmp("t5_sticky", 1, 32'(to1), 1);
    set_lu(4'd3, 4'd3, 4'd0, 1, 0);
    tick();
    idle();
    rst_n = 0;
    #1 cmp("t6_rst_outs", 1, 32'(outs1), 32'h04);
    tick();
    rst_n = 1;
    #1 cmp("t6_run", 1, 32'(outs1), 32'h38);
    cmp("t6_sc", 1, 32'(sc1), 0);
    cmp("t6_to", 1, 32'(to1), 0);
    tick();
    for (int i = 0; i < 12; i++) begin
      {mem_read, regw, wa, ra1, ra2, u1s, u2s, br, req, rdy} = vecs[i];
      tick();
    end
    idle();
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
